hwpe_stream_downsizer: RTL and testbench
========================================

// Module: hwpe_stream_downsizer
// PURPOSE
//  Serializes each wide stream word into RATIO narrow beats, least-significant slice first.
//  Sits directly downstream of the stream FIFO and consumes its pop side.
//  Feeds narrow consumers (e.g. 32-bit TCDM store path) from 64/128-bit FIFO streams.
//  Optionally drops slices whose byte strobes are all zero.
// PARAMETERS
//  DATA_WIDTH_IN  64  push-side data width in bits; multiple of 8*RATIO
//  RATIO          2   narrow beats per wide word, 1..256; DATA_WIDTH_OUT = DATA_WIDTH_IN/RATIO
//  SKIP_EMPTY     0   1: slices with all-zero strobe are not emitted
// PORTS
//  clk_i    in   1                  clock; single clock domain
//  rst_ni   in   1                  asynchronous reset, active-low
//  clear_i  in   1                  synchronous clear; same effect as reset
//  flags_o  out  flags_downsizer_t  {busy, beat_idx[7:0]}
//  push_i   sink                    hwpe_stream_intf_stream; data DATA_WIDTH_IN, strb DATA_WIDTH_IN/8
//  pop_o    src                     hwpe_stream_intf_stream; data DATA_WIDTH_OUT, strb DATA_WIDTH_OUT/8
// BEHAVIOUR
//  - State: busy flag, wide holding register {data,strb}, beat index idx (clog2(RATIO) bits, min 1).
//  - Reset / clear_i: busy=0, idx=0, holding register=0. pop_o.valid=0, flags_o=0. clear_i overrides all handshakes that cycle.
//  - Handshake: a transfer occurs when valid & ready on the same edge.
//    valid never depends on ready. valid is never withdrawn before its transfer. Data/strb are stable while valid & !ready.
//  - push_i.ready = !busy | (pop_o.ready & last), where last = no further beat to emit after idx.
//  - Push transfer: load register, busy=1, idx=first beat (0; with SKIP_EMPTY, lowest slice with nonzero strb).
//  - Latency: first narrow beat is valid on the cycle after the push transfer (registered; no combinational push->pop path).
//  - pop_o.valid = busy.
//  - pop_o.data/strb = slice idx of the register; driven '0 when !valid (matches FIFO convention).
//  - Pop transfer with !last: idx advances to the next beat. Next beat = idx+1, or with SKIP_EMPTY the next higher slice with nonzero strb.
//  - Pop transfer with last: if a push transfer occurs in the same cycle, the new word loads (no bubble; one beat per cycle sustained).
//    Otherwise busy=0 and idx=0.
//  - SKIP_EMPTY=1, pushed word with strb=='0: accepted and discarded. busy stays 0 and nothing is emitted.
//  - RATIO=1: behaves as a one-entry registered pipe stage with full throughput.
//  - Throughput: RATIO beats per wide word, or fewer with skipping; push side stalls meanwhile.
//  - flags_o.busy = busy; flags_o.beat_idx = idx zero-extended to 8 bits.
//  - Reset asserted mid-word: the partially sent word is lost; no further beats are emitted.
// STRUCTURE
//  - hwpe_stream_package: typedef flags_downsizer_t (logic busy; logic [7:0] beat_idx).
//  - Single module with no sub-modules.
//  - Next-nonzero-slice search is one combinational priority function inside the module, generated only when SKIP_EMPTY=1.
// TESTING
//  1. DATA_WIDTH_IN=64, RATIO=2; push 0x11112222_33334444, strb 0xFF, pop.ready=1
//     -> beats 0x33334444 then 0x11112222, strb 0xF each, on consecutive cycles from cycle+1.
//  2. Back-to-back pushes A,B, pop.ready=1
//     -> 4 beats in 4 consecutive cycles. push.ready high on A's last-beat cycle, so B loads with no bubble.
//  3. pop.ready held low for 5 cycles mid-word
//     -> valid/data/strb frozen at the same slice; idx unchanged; push.ready=0.
//  4. SKIP_EMPTY=1, RATIO=4, strb 0x0F0 (slice 1 only)
//     -> exactly one beat with slice 1 data, strb 0xF. Then push strb 0 -> accepted, no beat emitted.
//  5. clear_i pulsed with 1 beat of 2 pending
//     -> next cycle valid=0, flags_o=0, push.ready=1. A fresh word then serializes from slice 0.
//  6. rst_ni low asynchronously mid-word
//     -> pop.valid drops immediately with data '0; after release, idle with push.ready=1.

Source files
------------

// File: rtl/hwpe_stream_downsizer_pkg.sv
// Shared types for the stream downsizer: status flags and the serializer state encoding.
package hwpe_stream_downsizer_pkg;

  typedef struct packed {
    logic       busy;
    logic [7:0] beat_idx;
  } flags_downsizer_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } downsizer_state_e;

endpackage

// File: rtl/hwpe_stream_downsizer_if.sv
// Valid/ready stream bundle carrying data plus one strobe bit per byte.
// A beat transfers on a clock edge where valid & ready; valid never waits on ready,
// is held until its transfer, and data/strb stay stable while valid & !ready.
interface hwpe_stream_downsizer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_downsizer.sv
// Serializes each wide stream word into RATIO narrow beats, lowest slice first,
// optionally skipping slices whose byte strobes are all zero.
module hwpe_stream_downsizer
  import hwpe_stream_downsizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN = 64,
  parameter int unsigned RATIO         = 2,
  parameter int unsigned SKIP_EMPTY    = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  output flags_downsizer_t               flags_o,
  hwpe_stream_downsizer_if.slave         push_i,
  hwpe_stream_downsizer_if.master        pop_o
);

  localparam int unsigned DW_OUT = DATA_WIDTH_IN / RATIO;
  localparam int unsigned SW     = DW_OUT / 8;
  localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef logic [RATIO-1:0][DW_OUT-1:0] data_arr_t;
  typedef logic [RATIO-1:0][SW-1:0]     strb_arr_t;

  downsizer_state_e state_q, state_d;
  data_arr_t        data_q, data_d;
  strb_arr_t        strb_q, strb_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             push_ready, push_fire, pop_fire, last;
  logic             first_ok, next_ok;
  logic [IDX_W-1:0] first_idx, next_idx;

  if (SKIP_EMPTY != 0) begin : gen_skip
    // Returns {found, index} of the lowest slice at or above 'from' with any strobe set.
    function automatic logic [IDX_W:0] find_nz(input strb_arr_t s, input logic [IDX_W:0] from);
      logic [IDX_W:0] r;
      r = '0;
      for (int i = RATIO - 1; i >= 0; i--) begin
        if (i >= int'(from) && (|s[i])) r = {1'b1, IDX_W'(i)};
      end
      return r;
    endfunction

    assign {first_ok, first_idx} = find_nz(strb_arr_t'(push_i.strb), '0);
    assign {next_ok, next_idx}   = find_nz(strb_q, {1'b0, idx_q} + 1'b1);
  end else begin : gen_dense
    assign first_ok  = 1'b1;
    assign first_idx = '0;
    assign next_ok   = (idx_q != IDX_W'(RATIO - 1));
    assign next_idx  = idx_q + 1'b1;
  end

  assign last       = !next_ok;
  assign push_ready = (state_q == ST_IDLE) | (pop_o.ready & last);
  assign push_fire  = push_i.valid & push_ready;
  assign pop_fire   = (state_q == ST_BUSY) & pop_o.ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    strb_d  = strb_q;
    idx_d   = idx_q;
    // A push only succeeds while idle or on the last beat, so it always wins over pop.
    if (push_fire) begin
      data_d  = data_arr_t'(push_i.data);
      strb_d  = strb_arr_t'(push_i.strb);
      state_d = first_ok ? ST_BUSY : ST_IDLE;
      idx_d   = first_ok ? first_idx : '0;
    end else if (pop_fire) begin
      if (last) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d   = next_idx;
      end
    end
    if (clear_i) begin
      state_d = ST_IDLE;
      data_d  = '0;
      strb_d  = '0;
      idx_d   = '0;
    end
  end

  always_comb begin
    pop_o.valid      = (state_q == ST_BUSY);
    pop_o.data       = '0;
    pop_o.strb       = '0;
    if (state_q == ST_BUSY) begin
      pop_o.data = data_q[idx_q];
      pop_o.strb = strb_q[idx_q];
    end
    push_i.ready     = push_ready;
    flags_o.busy     = (state_q == ST_BUSY);
    flags_o.beat_idx = 8'(idx_q);
  end

endmodule

// File: tb/tb_hwpe_stream_downsizer.sv
// Bench for the downsizer: a dense 64->32 instance and a skipping 128->32 (RATIO=4) instance.
module tb_hwpe_stream_downsizer;
  import hwpe_stream_downsizer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hwpe_stream_downsizer_if #(.DATA_WIDTH(64))  p0_push ();
  hwpe_stream_downsizer_if #(.DATA_WIDTH(32))  p0_pop ();
  hwpe_stream_downsizer_if #(.DATA_WIDTH(128)) p1_push ();
  hwpe_stream_downsizer_if #(.DATA_WIDTH(32))  p1_pop ();
  flags_downsizer_t flags0, flags1;

  hwpe_stream_downsizer #(.DATA_WIDTH_IN(64), .RATIO(2), .SKIP_EMPTY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .flags_o(flags0),
    .push_i(p0_push), .pop_o(p0_pop)
  );

  hwpe_stream_downsizer #(.DATA_WIDTH_IN(128), .RATIO(4), .SKIP_EMPTY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .flags_o(flags1),
    .push_i(p1_push), .pop_o(p1_pop)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [35:0] exp_q0[$];
  logic [35:0] exp_q1[$];
  int          pop_cyc0[$];
  int          push_cyc0[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !clear) begin
      if (p0_pop.valid && p0_pop.ready) begin
        pop_cyc0.push_back(cyc);
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL dut0_extra_beat: got %0h want none", {p0_pop.strb, p0_pop.data});
        end else check("dut0_beat", {p0_pop.strb, p0_pop.data}, exp_q0.pop_front());
      end
      if (p1_pop.valid && p1_pop.ready) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL dut1_extra_beat: got %0h want none", {p1_pop.strb, p1_pop.data});
        end else check("dut1_beat", {p1_pop.strb, p1_pop.data}, exp_q1.pop_front());
      end
      if (!p0_pop.valid) check("dut0_idle_zero", {p0_pop.strb, p0_pop.data}, '0);
      if (!p1_pop.valid) check("dut1_idle_zero", {p1_pop.strb, p1_pop.data}, '0);
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [63:0] d, input logic [7:0] s);
    int n;
    n = 0;
    p0_push.valid = 1'b1; p0_push.data = d; p0_push.strb = s;
    @(negedge clk);
    while (!p0_push.ready && n < 50) begin @(negedge clk); n++; end
    check("dut0_push_accept", p0_push.ready, 1);
    push_cyc0.push_back(cyc);
    @(posedge clk); #1;
    p0_push.valid = 1'b0; p0_push.data = '0; p0_push.strb = '0;
  endtask

  task automatic push1(input logic [127:0] d, input logic [15:0] s);
    int n;
    n = 0;
    p1_push.valid = 1'b1; p1_push.data = d; p1_push.strb = s;
    @(negedge clk);
    while (!p1_push.ready && n < 50) begin @(negedge clk); n++; end
    check("dut1_push_accept", p1_push.ready, 1);
    @(posedge clk); #1;
    p1_push.valid = 1'b0; p1_push.data = '0; p1_push.strb = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    check("drain_pending", exp_q0.size() + exp_q1.size(), 0);
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic [35:0] e0;
    logic [35:0] e1;
  } vec0_t;

  vec0_t tbl[8];

  localparam logic [127:0] WIDE = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;

  initial begin
    tbl[0] = '{64'h11112222_33334444, 8'hFF, 36'hF_33334444, 36'hF_11112222};
    tbl[1] = '{64'hDEADBEEF_CAFEF00D, 8'h0F, 36'hF_CAFEF00D, 36'h0_DEADBEEF};
    tbl[2] = '{64'h01234567_89ABCDEF, 8'h3C, 36'hC_89ABCDEF, 36'h3_01234567};
    tbl[3] = '{64'h0, 8'h00, 36'h0, 36'h0};
    for (int i = 4; i < 8; i++) begin
      tbl[i].d  = {32'($urandom), 32'($urandom)};
      tbl[i].s  = 8'($urandom_range(0, 255));
      tbl[i].e0 = {tbl[i].s[3:0], tbl[i].d[31:0]};
      tbl[i].e1 = {tbl[i].s[7:4], tbl[i].d[63:32]};
    end

    rst_n = 1'b0; clear = 1'b0;
    p0_push.valid = 1'b0; p0_push.data = '0; p0_push.strb = '0; p0_pop.ready = 1'b0;
    p1_push.valid = 1'b0; p1_push.data = '0; p1_push.strb = '0; p1_pop.ready = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_dut0_valid", p0_pop.valid, 0);
    check("rst_dut0_flags", flags0, 0);
    check("rst_dut0_push_ready", p0_push.ready, 1);
    check("rst_dut1_valid", p1_pop.valid, 0);
    check("rst_dut1_flags", flags1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    p0_pop.ready = 1'b1; p1_pop.ready = 1'b1;

    // single word: first beat one cycle after the push, then the upper slice
    pop_cyc0.delete(); push_cyc0.delete();
    exp_q0.push_back(36'hF_33334444); exp_q0.push_back(36'hF_11112222);
    push0(64'h11112222_33334444, 8'hFF);
    wait_drain();
    check("latency_first_beat", pop_cyc0[0] - push_cyc0[0], 1);
    check("consecutive_beats", pop_cyc0[1] - pop_cyc0[0], 1);

    // table of words, each fully drained
    for (int i = 0; i < 8; i++) begin
      exp_q0.push_back(tbl[i].e0); exp_q0.push_back(tbl[i].e1);
      push0(tbl[i].d, tbl[i].s);
    end
    wait_drain();

    // back-to-back words: B accepted on A's last-beat cycle, 4 beats in 4 cycles
    pop_cyc0.delete(); push_cyc0.delete();
    exp_q0.push_back(36'hF_A0A0A0A0); exp_q0.push_back(36'hF_A1A1A1A1);
    exp_q0.push_back(36'h5_B0B0B0B0); exp_q0.push_back(36'hA_B1B1B1B1);
    push0(64'hA1A1A1A1_A0A0A0A0, 8'hFF);
    push0(64'hB1B1B1B1_B0B0B0B0, 8'hA5);
    wait_drain();
    check("b2b_beat_count", pop_cyc0.size(), 4);
    check("b2b_span", pop_cyc0[3] - pop_cyc0[0], 3);
    check("b2b_no_bubble", push_cyc0[1], pop_cyc0[1]);

    // pop stall mid-word: output frozen on slice 1, push side blocked
    p0_pop.ready = 1'b0;
    exp_q0.push_back(36'hF_55556666); exp_q0.push_back(36'h3_77778888);
    push0(64'h77778888_55556666, 8'h3F);
    p0_pop.ready = 1'b1;
    tick(1);
    p0_pop.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", p0_pop.valid, 1);
      check("stall_data", {p0_pop.strb, p0_pop.data}, 36'h3_77778888);
      check("stall_idx", flags0.beat_idx, 1);
      check("stall_push_ready", p0_push.ready, 0);
    end
    @(posedge clk); #1;
    p0_pop.ready = 1'b1;
    wait_drain();

    // clear with one of two beats still pending
    exp_q0.push_back(36'hF_CCCC0000);
    push0(64'hDDDD1111_CCCC0000, 8'hFF);
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    @(negedge clk);
    check("clear_valid", p0_pop.valid, 0);
    check("clear_flags", flags0, 0);
    check("clear_push_ready", p0_push.ready, 1);
    check("clear_lost_beat", exp_q0.size(), 0);
    tick(1);
    exp_q0.push_back(36'hF_0BAD0001); exp_q0.push_back(36'hF_0BAD0002);
    push0(64'h0BAD0002_0BAD0001, 8'hFF);
    wait_drain();

    // asynchronous reset mid-word: beats dropped at once
    p0_pop.ready = 1'b0;
    push0(64'hFEEDFACE_12345678, 8'hFF);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", p0_pop.valid, 0);
    check("arst_data", {p0_pop.strb, p0_pop.data}, 0);
    check("arst_flags", flags0, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    p0_pop.ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", p0_pop.valid, 0);
    check("post_rst_push_ready", p0_push.ready, 1);
    check("post_rst_flags", flags0, 0);
    tick(3);

    // skipping instance: only slices with a strobe bit set are emitted
    exp_q1.push_back({4'hF, WIDE[63:32]});
    push1(WIDE, 16'h00F0);
    wait_drain();
    check("skip_idle_after", flags1.busy, 0);

    push1(WIDE, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("skip_empty_no_valid", p1_pop.valid, 0);
    end
    tick(1);

    exp_q1.push_back({4'hF, WIDE[31:0]});   exp_q1.push_back({4'hF, WIDE[127:96]});
    exp_q1.push_back({4'h1, WIDE[31:0]});   exp_q1.push_back({4'h2, WIDE[63:32]});
    exp_q1.push_back({4'h4, WIDE[95:64]});  exp_q1.push_back({4'h8, WIDE[127:96]});
    exp_q1.push_back({4'h2, WIDE[95:64]});  exp_q1.push_back({4'h1, WIDE[127:96]});
    push1(WIDE, 16'hF00F);
    push1(WIDE, 16'h8421);
    push1(WIDE, 16'h1200);
    wait_drain();

    check("end_q0_empty", exp_q0.size(), 0);
    check("end_q1_empty", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
